// File: rtl/scalar_seq.sv
// rtl/scalar_seq.sv - scalar instruction sequencer and register file driving the scalar PE
// Two-cycle ISSUE/EXEC issue loop; lui retires locally, addi/add/bne are delegated to the PE.
module scalar_seq #(
    parameter int dwidth_int = 32,
    parameter int NREG = 8,
    parameter int IMEM_DEPTH = 16,
    parameter int IMM_W = 16,
    localparam int AW = $clog2(IMEM_DEPTH),
    localparam int RW = $clog2(NREG),
    localparam int IW = 3 + 3 * RW + IMM_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_we,
    input  logic [AW-1:0]         imem_addr,
    input  logic [IW-1:0]         imem_wdata,
    input  logic [AW:0]           prog_len,
    input  logic                  start,
    output logic [2:0]            op_scalar,
    output logic [dwidth_int-1:0] inp1,
    output logic [dwidth_int-1:0] inp2,
    output logic [dwidth_int-1:0] R_immediate,
    input  logic [dwidth_int-1:0] out1,
    input  logic                  flag_neq,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         pc_dbg
);

    localparam logic [2:0] OP_LUI  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [AW-1:0]         pc;
    logic [AW:0]           len_q;
    logic [IW-1:0]         ir;
    logic [IW-1:0]         imem [IMEM_DEPTH];
    logic [dwidth_int-1:0] rf [NREG];

    logic [2:0]            ir_op;
    logic [RW-1:0]         ir_rd;
    logic [RW-1:0]         ir_rs1;
    logic [RW-1:0]         ir_rs2;
    logic [IMM_W-1:0]      ir_imm;
    logic [IMM_W-1:0]      fetch_imm;
    logic [dwidth_int-1:0] rs1_val;
    logic [dwidth_int-1:0] rs2_val;
    logic [dwidth_int-1:0] lui_val;
    logic [AW:0]           next_seq;
    logic                  seq_end;

    logic                  wr_en;
    logic [dwidth_int-1:0] wr_data;
    logic [AW-1:0]         pc_next;
    logic                  exec_to_done;

    function automatic logic [dwidth_int-1:0] sext(input logic [IMM_W-1:0] v);
        return {{(dwidth_int - IMM_W){v[IMM_W-1]}}, v};
    endfunction

    assign ir_op     = ir[IW-1 -: 3];
    assign ir_rd     = ir[IW-4 -: RW];
    assign ir_rs1    = ir[IW-4-RW -: RW];
    assign ir_rs2    = ir[IW-4-2*RW -: RW];
    assign ir_imm    = ir[IMM_W-1:0];
    assign fetch_imm = imem[pc][IMM_W-1:0];

    assign rs1_val  = (ir_rs1 == '0) ? '0 : rf[ir_rs1];
    assign rs2_val  = (ir_rs2 == '0) ? '0 : rf[ir_rs2];
    assign lui_val  = {ir_imm, {(dwidth_int - IMM_W){1'b0}}};
    // Length check uses the unwrapped sequential pc so the last slot (pc=15) can still terminate.
    assign next_seq = {1'b0, pc} + {{AW{1'b0}}, 1'b1};
    assign seq_end  = (next_seq >= len_q);

    always_comb begin
        wr_en        = 1'b0;
        wr_data      = out1;
        pc_next      = next_seq[AW-1:0];
        exec_to_done = seq_end;
        case (ir_op)
            OP_LUI: begin
                wr_en   = (ir_rd != '0);
                wr_data = lui_val;
            end
            OP_ADDI, OP_ADD: wr_en = (ir_rd != '0);
            OP_BNE: begin
                // Taken targets wrap modulo the program memory and are never length-checked.
                if (flag_neq) begin
                    pc_next      = pc + ir_imm[AW-1:0];
                    exec_to_done = 1'b0;
                end
            end
            OP_HALT: exec_to_done = 1'b1;
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= '0;
            len_q <= '0;
            ir    <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        len_q <= prog_len;
                        state <= (prog_len == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ir    <= imem[pc];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (wr_en) begin
                        rf[ir_rd] <= wr_data;
                    end
                    pc    <= pc_next;
                    state <= exec_to_done ? S_DONE : S_ISSUE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Program memory is deliberately outside the reset domain so a preloaded program survives reset.
    always_ff @(posedge clk) begin
        if (rst && imem_we && (state == S_IDLE)) begin
            imem[imem_addr] <= imem_wdata;
        end
    end

    always_comb begin
        op_scalar   = OP_HALT;
        inp1        = '0;
        inp2        = '0;
        R_immediate = '0;
        case (state)
            S_ISSUE: R_immediate = sext(fetch_imm);
            S_EXEC: begin
                op_scalar   = ir_op;
                inp1        = rs1_val;
                inp2        = rs2_val;
                R_immediate = sext(ir_imm);
            end
            default: op_scalar = OP_HALT;
        endcase
    end

    assign busy   = (state == S_ISSUE) || (state == S_EXEC);
    assign done   = (state == S_DONE);
    assign pc_dbg = pc;

endmodule

// File: tb/tb_scalar_seq.sv
// tb/tb_scalar_seq.sv - self-checking bench for scalar_seq with a stand-in PE and instruction-level model
module tb_scalar_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [27:0] imem_wdata;
    logic [4:0]  prog_len;
    logic        start;
    logic [2:0]  op_scalar;
    logic [31:0] inp1, inp2, R_immediate, out1;
    logic        flag_neq;
    logic        busy, done;
    logic [3:0]  pc_dbg;

    int total = 0;
    int bad = 0;

    scalar_seq dut (
        .clk(clk), .rst(rst), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .prog_len(prog_len), .start(start), .op_scalar(op_scalar), .inp1(inp1), .inp2(inp2),
        .R_immediate(R_immediate), .out1(out1), .flag_neq(flag_neq), .busy(busy), .done(done),
        .pc_dbg(pc_dbg)
    );

    always #5 clk = ~clk;

    // Stand-in scalar PE: registers the immediate, computes combinationally during EXEC.
    logic [31:0] imm_q;
    always @(posedge clk) imm_q <= R_immediate;
    assign out1 = (op_scalar == 3'b001) ? inp1 + imm_q :
                  (op_scalar == 3'b011) ? inp1 + inp2 : 32'h0;
    assign flag_neq = (op_scalar == 3'b010) && (inp1 != inp2);

    logic [2:0]  obs_op[$];
    logic [31:0] obs_a[$];
    logic [31:0] obs_b[$];
    logic [3:0]  obs_pc[$];
    logic        obs_busy[$];
    int          obs_cycles;
    logic        obs_done2;
    logic [31:0] obs_rf[8];

    logic [27:0] mimem[16];
    logic [31:0] mrf[8];
    logic [2:0]  exp_op[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int          exp_pc[$];
    int          exp_n;

    function automatic logic [27:0] enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
        return {op[2:0], rd[2:0], rs1[2:0], rs2[2:0], imm[15:0]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) mrf[i] = 32'h0;
    endtask

    task automatic load(input int a, input logic [27:0] w);
        @(negedge clk);
        imem_we = 1'b1;
        imem_addr = a[3:0];
        imem_wdata = w;
        @(posedge clk);
        #1;
        imem_we = 1'b0;
        mimem[a] = w;
    endtask

    // Runs one program from pc=0 and records what the DUT presents each cycle until done.
    task automatic drive(input int len, input int poke_at, input bit we_start, input logic [27:0] w);
        obs_op.delete(); obs_a.delete(); obs_b.delete(); obs_pc.delete(); obs_busy.delete();
        obs_cycles = -1;
        obs_done2 = 1'bx;
        @(negedge clk);
        prog_len = len[4:0];
        start = 1'b1;
        if (we_start) begin
            imem_we = 1'b1; imem_addr = 4'd0; imem_wdata = w;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        imem_we = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            obs_op.push_back(op_scalar); obs_a.push_back(inp1); obs_b.push_back(inp2);
            obs_pc.push_back(pc_dbg); obs_busy.push_back(busy);
            if (done === 1'b1) begin
                obs_cycles = k;
                break;
            end
            if (k == poke_at) begin
                imem_we = 1'b1; imem_addr = 4'd0; imem_wdata = w; start = 1'b1;
            end
            @(posedge clk);
            #1;
            imem_we = 1'b0;
            start = 1'b0;
        end
        if (obs_cycles >= 0) begin
            @(posedge clk);
            @(negedge clk);
            obs_done2 = done;
        end
    endtask

    // Dumps the register file through inp1/inp2 using add r0,rX,rY (writes to r0 are dropped).
    task automatic readback();
        for (int k = 0; k < 4; k++) load(k, enc(3, 0, 2 * k, 2 * k + 1, 0));
        drive(4, -1, 1'b0, 28'h0);
        for (int k = 0; k < 8; k++) obs_rf[k] = 32'hx;
        if (obs_cycles == 8) begin
            for (int k = 0; k < 4; k++) begin
                obs_rf[2 * k] = obs_a[2 * k + 1];
                obs_rf[2 * k + 1] = obs_b[2 * k + 1];
            end
        end
    endtask

    // Instruction-level reference: walks mimem from pc 0, updating mrf and the expected EXEC trace.
    task automatic model(input int len);
        int pc, op, rd, rs1, rs2;
        logic [27:0] w;
        logic [31:0] a, b, simm;
        bit stop;
        exp_op.delete(); exp_a.delete(); exp_b.delete(); exp_pc.delete();
        pc = 0; exp_n = 0; stop = 0;
        while (!stop && exp_n < 64) begin
            w = mimem[pc];
            op = w[27:25]; rd = w[24:22]; rs1 = w[21:19]; rs2 = w[18:16];
            simm = {{16{w[15]}}, w[15:0]};
            a = (rs1 == 0) ? 32'h0 : mrf[rs1];
            b = (rs2 == 0) ? 32'h0 : mrf[rs2];
            exp_pc.push_back(pc); exp_op.push_back(op[2:0]); exp_a.push_back(a); exp_b.push_back(b);
            exp_n++;
            if (op == 7) stop = 1;
            else if (op == 2 && a != b) pc = (pc + int'(simm)) & 15;
            else begin
                if (op == 0 && rd != 0) mrf[rd] = {w[15:0], 16'h0};
                if (op == 1 && rd != 0) mrf[rd] = a + simm;
                if (op == 3 && rd != 0) mrf[rd] = a + b;
                pc = pc + 1;
                if (pc >= len) stop = 1;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] want [3];
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        total++; if (op_scalar !== 3'b111) begin bad++; $display("FAIL reset_op got %b want 111", op_scalar); end
        total++; if (inp1 !== 32'h0 || inp2 !== 32'h0) begin bad++; $display("FAIL reset_inp got %h/%h want 0/0", inp1, inp2); end
        total++; if (R_immediate !== 32'h0) begin bad++; $display("FAIL reset_imm got %h want 0", R_immediate); end
        total++; if (pc_dbg !== 4'd0) begin bad++; $display("FAIL reset_pc got %0d want 0", pc_dbg); end
        rst = 1'b1;
        for (int i = 0; i < 16; i++) load(i, enc(7, 0, 0, 0, 0));
        readback();
        for (int k = 0; k < 8; k++) begin
            total++; if (obs_rf[k] !== 32'h0) begin bad++; $display("FAIL reset_rf r%0d got %h want 0", k, obs_rf[k]); end
        end
        load(0, enc(1, 1, 1, 0, 5));
        load(1, enc(0, 2, 0, 0, 16'h00ab));
        load(2, enc(3, 3, 1, 2, 0));
        drive(3, -1, 1'b0, 28'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(3, -1, 1'b0, 28'h0);
        total++; if (obs_cycles !== 6) begin bad++; $display("FAIL reset_rerun_cycles got %0d want 6", obs_cycles); end
        readback();
        want = '{32'h5, 32'h00ab0000, 32'h00ab0005};
        for (int k = 0; k < 3; k++) begin
            total++; if (obs_rf[k + 1] !== want[k]) begin bad++; $display("FAIL reset_prog_intact r%0d got %h want %h", k + 1, obs_rf[k + 1], want[k]); end
        end
    endtask

    task automatic test_straight();
        do_reset();
        load(0, enc(0, 1, 0, 0, 16'h0001));
        load(1, enc(1, 2, 1, 0, 5));
        load(2, enc(3, 3, 1, 2, 0));
        drive(3, -1, 1'b0, 28'h0);
        total++; if (obs_cycles !== 6) begin bad++; $display("FAIL straight_cycles got %0d want 6", obs_cycles); end
        total++; if (obs_done2 !== 1'b0) begin bad++; $display("FAIL straight_done_pulse got %b want 0", obs_done2); end
        if (obs_cycles == 6) begin
            total++; if (obs_busy[0] !== 1'b1 || obs_op[0] !== 3'b111) begin bad++; $display("FAIL straight_issue got busy=%b op=%b want 1/111", obs_busy[0], obs_op[0]); end
            total++; if (obs_op[1] !== 3'b000) begin bad++; $display("FAIL straight_first_op got %b want 000", obs_op[1]); end
            total++; if (obs_op[5] !== 3'b011 || obs_a[5] !== 32'h00010000 || obs_b[5] !== 32'h00010005) begin
                bad++; $display("FAIL straight_add_operands got %b %h %h want 011 00010000 00010005", obs_op[5], obs_a[5], obs_b[5]); end
        end
        readback();
        total++; if (obs_rf[1] !== 32'h00010000) begin bad++; $display("FAIL straight_r1 got %h want 00010000", obs_rf[1]); end
        total++; if (obs_rf[2] !== 32'h00010005) begin bad++; $display("FAIL straight_r2 got %h want 00010005", obs_rf[2]); end
        total++; if (obs_rf[3] !== 32'h00020005) begin bad++; $display("FAIL straight_r3 got %h want 00020005", obs_rf[3]); end
    endtask

    task automatic test_loop();
        int taken;
        do_reset();
        load(0, enc(1, 1, 0, 0, 4));
        load(1, enc(1, 2, 2, 0, 1));
        load(2, enc(1, 1, 1, 0, -1));
        load(3, enc(2, 0, 1, 0, -2));
        drive(4, -1, 1'b0, 28'h0);
        total++; if (obs_cycles !== 26) begin bad++; $display("FAIL loop_cycles got %0d want 26", obs_cycles); end
        taken = 0;
        for (int k = 0; k + 1 < obs_op.size(); k++) if (obs_op[k] == 3'b010 && obs_pc[k + 1] == 4'd1) taken++;
        total++; if (taken !== 3) begin bad++; $display("FAIL loop_taken got %0d want 3", taken); end
        readback();
        total++; if (obs_rf[1] !== 32'h0) begin bad++; $display("FAIL loop_r1 got %h want 0", obs_rf[1]); end
        total++; if (obs_rf[2] !== 32'h4) begin bad++; $display("FAIL loop_r2 got %h want 4", obs_rf[2]); end
    endtask

    task automatic test_halt();
        do_reset();
        load(0, enc(1, 0, 0, 0, 7));
        load(1, enc(7, 0, 0, 0, 0));
        load(2, enc(1, 4, 0, 0, 9));
        drive(3, -1, 1'b0, 28'h0);
        total++; if (obs_cycles !== 4) begin bad++; $display("FAIL halt_cycles got %0d want 4", obs_cycles); end
        readback();
        total++; if (obs_rf[0] !== 32'h0) begin bad++; $display("FAIL halt_r0 got %h want 0", obs_rf[0]); end
        total++; if (obs_rf[4] !== 32'h0) begin bad++; $display("FAIL halt_r4 got %h want 0", obs_rf[4]); end
    endtask

    task automatic test_len_zero();
        drive(0, -1, 1'b0, 28'h0);
        total++; if (obs_cycles !== 0) begin bad++; $display("FAIL len0_cycles got %0d want 0", obs_cycles); end
        if (obs_op.size() > 0) begin
            total++; if (obs_op[0] !== 3'b111 || obs_busy[0] !== 1'b0) begin bad++; $display("FAIL len0_quiet got op=%b busy=%b want 111/0", obs_op[0], obs_busy[0]); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        load(0, enc(0, 1, 0, 0, 1));
        drive(1, -1, 1'b0, 28'h0);
        load(0, enc(2, 0, 1, 0, -1));
        load(15, enc(7, 0, 0, 0, 0));
        drive(1, -1, 1'b0, 28'h0);
        total++; if (obs_cycles !== 4) begin bad++; $display("FAIL wrap_cycles got %0d want 4", obs_cycles); end
        if (obs_pc.size() > 2) begin
            total++; if (obs_pc[2] !== 4'd15) begin bad++; $display("FAIL wrap_pc got %0d want 15", obs_pc[2]); end
        end
    endtask

    task automatic test_busy_ignore();
        do_reset();
        for (int i = 0; i < 4; i++) load(i, enc(1, 6, 6, 0, 1));
        drive(4, 2, 1'b0, enc(7, 0, 0, 0, 0));
        total++; if (obs_cycles !== 8) begin bad++; $display("FAIL busy_start_cycles got %0d want 8", obs_cycles); end
        drive(4, -1, 1'b0, 28'h0);
        total++; if (obs_cycles !== 8) begin bad++; $display("FAIL busy_write_cycles got %0d want 8", obs_cycles); end
        readback();
        total++; if (obs_rf[6] !== 32'h8) begin bad++; $display("FAIL busy_r6 got %h want 8", obs_rf[6]); end
    endtask

    task automatic test_start_with_write();
        drive(1, -1, 1'b1, enc(0, 7, 0, 0, 16'h5555));
        mimem[0] = enc(0, 7, 0, 0, 16'h5555);
        total++; if (obs_cycles !== 2) begin bad++; $display("FAIL startwr_cycles got %0d want 2", obs_cycles); end
        readback();
        total++; if (obs_rf[7] !== 32'h55550000) begin bad++; $display("FAIL startwr_r7 got %h want 55550000", obs_rf[7]); end
    endtask

    task automatic test_reset_midrun();
        bit seen;
        do_reset();
        load(0, enc(1, 1, 0, 0, 1));
        load(1, enc(1, 5, 0, 0, 9));
        @(negedge clk);
        prog_len = 5'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (op_scalar !== 3'b001) begin bad++; $display("FAIL midrun_in_exec got %b want 001", op_scalar); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || pc_dbg !== 4'd0) begin bad++; $display("FAIL midrun_idle got busy=%b pc=%0d want 0/0", busy, pc_dbg); end
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b0) seen = 1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrun_done got %b want 0", seen); end
        readback();
        total++; if (obs_rf[5] !== 32'h0) begin bad++; $display("FAIL midrun_r5 got %h want 0", obs_rf[5]); end
        total++; if (obs_rf[1] !== 32'h0) begin bad++; $display("FAIL midrun_r1 got %h want 0", obs_rf[1]); end
    endtask

    task automatic test_random();
        int len, r, op, imm;
        do_reset();
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                imm = $urandom_range(0, 65535);
                case (r)
                    0, 1: op = 0;
                    2, 3: op = 1;
                    4, 5: op = 3;
                    6, 7: begin op = 2; imm = $urandom_range(1, 3); end
                    8: op = $urandom_range(4, 6);
                    default: op = 7;
                endcase
                load(i, enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), imm));
            end
            model(len);
            drive(len, -1, 1'b0, 28'h0);
            total++; if (obs_cycles !== 2 * exp_n) begin bad++; $display("FAIL rand_cycles it=%0d got %0d want %0d", it, obs_cycles, 2 * exp_n); end
            if (obs_cycles == 2 * exp_n) begin
                for (int i = 0; i < exp_n; i++) begin
                    total++;
                    if (obs_pc[2 * i] !== exp_pc[i][3:0] || obs_op[2 * i + 1] !== exp_op[i] ||
                        obs_a[2 * i + 1] !== exp_a[i] || obs_b[2 * i + 1] !== exp_b[i]) begin
                        bad++;
                        $display("FAIL rand_trace it=%0d i=%0d got pc=%0d op=%b a=%h b=%h want pc=%0d op=%b a=%h b=%h", it, i,
                                 obs_pc[2 * i], obs_op[2 * i + 1], obs_a[2 * i + 1], obs_b[2 * i + 1],
                                 exp_pc[i], exp_op[i], exp_a[i], exp_b[i]);
                    end
                end
            end
        end
        readback();
        for (int k = 0; k < 8; k++) begin
            total++; if (obs_rf[k] !== mrf[k]) begin bad++; $display("FAIL rand_rf r%0d got %h want %h", k, obs_rf[k], mrf[k]); end
        end
    endtask

    initial begin
        rst = 1'b0;
        imem_we = 1'b0;
        imem_addr = 4'd0;
        imem_wdata = 28'h0;
        prog_len = 5'd0;
        start = 1'b0;
        test_reset();
        test_straight();
        test_loop();
        test_halt();
        test_len_zero();
        test_wrap();
        test_busy_ignore();
        test_start_with_write();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
